// File: rtl/seg7_pattern_decoder.sv
`timescale 1ns/1ps
// Inverse seven-segment decoder: filters strobed, multiplexed active-low segment
// patterns for stability and rebuilds the 8-digit hex readback word.
module seg7_pattern_decoder #(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [6:0]  seg_in,
  input  logic [2:0]  dig_sel,
  input  logic        seg_strobe,
  input  logic        clear,
  output logic [31:0] value,
  output logic [7:0]  digit_valid,
  output logic [7:0]  digit_blank,
  output logic [7:0]  digit_err,
  output logic        update,
  output logic [2:0]  update_pos,
  output logic        frame_done
);

  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  logic [2:0]       last_pos;
  logic [6:0]       last_pat;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       seen;

  logic             match;
  logic [CNT_W-1:0] cnt_nxt;
  logic             commit;
  logic             is_hex;
  logic             is_blank;
  logic [3:0]       code;
  logic [7:0]       pos_bit;
  logic [7:0]       seen_nxt;

  // Stability filter: count repeats of the same (position, pattern) pair
  always_comb begin
    match   = (dig_sel == last_pos) && (seg_in == last_pat);
    cnt_nxt = cnt;
    commit  = 1'b0;
    if (seg_strobe) begin
      if (!match) begin
        cnt_nxt = CNT_W'(1);
      end else if (cnt != STABLE) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      // Commit only on the transition into STABLE, never while already saturated
      commit = (cnt_nxt == STABLE) && !(match && (cnt == STABLE));
    end
  end

  // Exact-match decode table (gfedcba, active low)
  always_comb begin
    is_hex   = 1'b1;
    is_blank = 1'b0;
    code     = 4'h0;
    case (seg_in)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0001000: code = 4'hA;
      7'b0000011: code = 4'hB;
      7'b0100111: code = 4'hC;
      7'b0100001: code = 4'hD;
      7'b0000110: code = 4'hE;
      7'b0001110: code = 4'hF;
      PAT_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default: is_hex = 1'b0;
    endcase
  end

  always_comb begin
    pos_bit  = 8'(1) << dig_sel;
    seen_nxt = seen | pos_bit;
  end

  // Capture registers; clear shares reset values except update_pos
  always_ff @(posedge CLOCK_50) begin
    if (RST || clear) begin
      last_pos    <= 3'd0;
      last_pat    <= PAT_BLANK;
      cnt         <= '0;
      seen        <= 8'h00;
      value       <= 32'h0;
      digit_valid <= 8'h00;
      digit_blank <= 8'h00;
      digit_err   <= 8'h00;
      update      <= 1'b0;
      frame_done  <= 1'b0;
      if (RST) begin
        update_pos <= 3'd0;
      end
    end else begin
      update     <= commit;
      frame_done <= 1'b0;
      if (seg_strobe) begin
        last_pos <= dig_sel;
        last_pat <= seg_in;
        cnt      <= cnt_nxt;
      end
      if (commit) begin
        update_pos <= dig_sel;
        if (seen_nxt == 8'hFF) begin
          frame_done <= 1'b1;
          seen       <= 8'h00;
        end else begin
          seen <= seen_nxt;
        end
        if (is_hex) begin
          value[{dig_sel, 2'b00} +: 4] <= code;
          digit_valid <= digit_valid | pos_bit;
          digit_blank <= digit_blank & ~pos_bit;
          digit_err   <= digit_err & ~pos_bit;
        end else if (is_blank) begin
          value[{dig_sel, 2'b00} +: 4] <= 4'h0;
          digit_valid <= digit_valid & ~pos_bit;
          digit_blank <= digit_blank | pos_bit;
          digit_err   <= digit_err & ~pos_bit;
        end else begin
          digit_valid <= digit_valid & ~pos_bit;
          digit_blank <= digit_blank & ~pos_bit;
          digit_err   <= digit_err | pos_bit;
        end
      end
    end
  end

endmodule
